// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Types and constants shared by the data-memory arbiter and its sub-module.
//   arb_state_e : arbiter response state (OWN_CPU / DMA_RSP)
//   FUNCT3_WORD : funct3 size code for a 32-bit word access
// Widths stay module parameters.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    DMA_RSP = 1'b1
  } arb_state_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// This counter tracks how long a pending DMA request has been waiting.
// Its value saturates at MAX_WAIT.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   i_inc   : count one more waiting cycle (held at MAX_WAIT)
//   i_clr   : clear to zero (has priority over i_inc)
//   o_sat   : count equals MAX_WAIT
//   o_cnt   : current count
// -----------------------------------------------------------------------------
module starve_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = (r_cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = w_sat;
  assign o_cnt = r_cnt;

endmodule : starve_counter

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// This block arbitrates the data memory between the CPU MEM stage and a
// debug/DMA port. It issues at most one access per cycle.
//
// Arbitration rules:
//   - The CPU normally wins.
//   - The DMA wins when the CPU is idle.
//   - The DMA also wins once it has waited MAX_WAIT cycles.
//   - When the DMA wins over an active CPU request, the pipeline is stalled
//     through cpu_stall.
//
// DMA read data is registered and returned one cycle later with a
// dma_rvalid pulse.
//
// Ports:
//   clk, reset                  : clock, async active-low reset
//   cpu_rd/wr/addr/wdata/funct3 : MEM-stage request (write wins if rd & wr)
//   cpu_rdata, cpu_stall        : load data back to MEM/WB, pipeline freeze
//   dma_req/we/addr/wdata       : DMA request, held until dma_gnt
//   dma_gnt                     : DMA access issued this cycle
//   dma_rvalid, dma_rdata       : registered DMA read response
//   mem_rd/wr/addr/wdata/funct3 : data-memory port
//   mem_rdata                   : data-memory read data (same cycle)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_e       r_state;
  logic [DATA_W-1:0] r_dma_rdata;

  logic             w_cpu_req;
  logic             w_dma_win;
  logic             w_cpu_win;
  logic             w_wait_sat;
  logic [CNT_W-1:0] w_wait_cnt;

  assign w_cpu_req = cpu_rd | cpu_wr;

  // After a forced grant the counter clears, so the CPU wins the next cycle.
  assign w_dma_win = dma_req & (~w_cpu_req | w_wait_sat);
  assign w_cpu_win = w_cpu_req & ~w_dma_win;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .i_inc (dma_req & ~w_dma_win),
    .i_clr (~dma_req | w_dma_win),
    .o_sat (w_wait_sat),
    .o_cnt (w_wait_cnt)
  );

  // The memory port is steered combinationally. A simultaneous CPU rd and wr
  // is treated as a write.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    cpu_rdata  = '0;
    if (w_dma_win) begin
      mem_rd     = ~dma_we;
      mem_wr     = dma_we;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
      mem_funct3 = FUNCT3_WORD;
    end else if (w_cpu_win) begin
      mem_rd    = cpu_rd & ~cpu_wr;
      mem_wr    = cpu_wr;
      cpu_rdata = mem_rdata;
    end
  end

  assign dma_gnt   = w_dma_win;
  assign cpu_stall = w_dma_win & w_cpu_req;

  // Every DMA read grant enters DMA_RSP for exactly one cycle.
  // A new grant is legal while in DMA_RSP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= OWN_CPU;
      r_dma_rdata <= '0;
    end else if (w_dma_win && !dma_we) begin
      r_state     <= DMA_RSP;
      r_dma_rdata <= mem_rdata;
    end else begin
      r_state <= OWN_CPU;
    end
  end

  assign dma_rvalid = (r_state == DMA_RSP);
  assign dma_rdata  = r_dma_rdata;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int MAX_WAIT   = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cpu_rd, cpu_wr;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_funct3;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_stall;
  logic                  dma_req, dma_we;
  logic [DM_ADDRESS-1:0] dma_addr;
  logic [DATA_W-1:0]     dma_wdata;
  logic                  dma_gnt, dma_rvalid;
  logic [DATA_W-1:0]     dma_rdata;
  logic                  mem_rd, mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W     (DATA_W),
    .DM_ADDRESS (DM_ADDRESS),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b000;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset state, checked before any clock edge
    #2;
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_rdata",  dma_rdata, 0);
    chk("rst_gnt",    dma_gnt, 0);
    chk("rst_memrd",  mem_rd, 0);
    chk("rst_memwr",  mem_wr, 0);
    chk("rst_stall",  cpu_stall, 0);
    chk("rst_cnt",    dut.u_starve.r_cnt, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;

    // CPU load, uncontended
    next_cycle();
    cpu_rd = 1; cpu_addr = 9'h010; cpu_funct3 = 3'b010; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("s1_memrd",  mem_rd, 1);
    chk("s1_memwr",  mem_wr, 0);
    chk("s1_addr",   mem_addr, 9'h010);
    chk("s1_rdata",  cpu_rdata, 32'hDEADBEEF);
    chk("s1_stall",  cpu_stall, 0);
    chk("s1_gnt",    dma_gnt, 0);

    // DMA read with the CPU idle
    next_cycle();
    idle_inputs();
    dma_req = 1; dma_we = 0; dma_addr = 9'h020; mem_rdata = 32'h12345678;
    #1;
    chk("s2_gnt",    dma_gnt, 1);
    chk("s2_memrd",  mem_rd, 1);
    chk("s2_addr",   mem_addr, 9'h020);
    chk("s2_f3",     mem_funct3, 3'b010);
    chk("s2_cpurd",  cpu_rdata, 0);
    chk("s2_stall",  cpu_stall, 0);
    next_cycle();
    idle_inputs();
    #1;
    chk("s2_rvalid1", dma_rvalid, 1);
    chk("s2_rdata1",  dma_rdata, 32'h12345678);
    chk("s2_gnt1",    dma_gnt, 0);
    next_cycle();
    #1;
    chk("s2_rvalid2", dma_rvalid, 0);
    chk("s2_rdhold",  dma_rdata, 32'h12345678);

    // CPU read and write together: treated as a write
    next_cycle();
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 9'h044; cpu_wdata = 32'hA5A5A5A5; cpu_funct3 = 3'b010;
    #1;
    chk("s4_memwr",  mem_wr, 1);
    chk("s4_memrd",  mem_rd, 0);
    chk("s4_wdata",  mem_wdata, 32'hA5A5A5A5);
    chk("s4_stall",  cpu_stall, 0);

    // DMA starved behind a continuous CPU load
    next_cycle();
    idle_inputs();
    cpu_rd = 1; cpu_addr = 9'h004; cpu_funct3 = 3'b100;
    dma_req = 1; dma_we = 1; dma_addr = 9'h030; dma_wdata = 32'h5555AAAA;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      mem_rdata = 32'h10000000 + c;
      #1;
      chk($sformatf("s3_gnt_c%0d", c),   dma_gnt,   (c == 4));
      chk($sformatf("s3_stall_c%0d", c), cpu_stall, (c == 4));
      chk($sformatf("s3_memrd_c%0d", c), mem_rd,    (c != 4));
      chk($sformatf("s3_memwr_c%0d", c), mem_wr,    (c == 4));
      chk($sformatf("s3_addr_c%0d", c),  mem_addr,  (c == 4) ? 9'h030 : 9'h004);
      chk($sformatf("s3_cpurd_c%0d", c), cpu_rdata, (c == 4) ? 32'h0 : 32'h10000000 + c);
    end
    chk("s3_cnt_c5", dut.u_starve.r_cnt, 0);

    // DMA write with the CPU idle: no response pulse
    next_cycle();
    idle_inputs();
    dma_req = 1; dma_we = 1; dma_addr = 9'h040; dma_wdata = 32'h0000FFFF;
    #1;
    chk("s5_gnt",    dma_gnt, 1);
    chk("s5_memwr",  mem_wr, 1);
    chk("s5_memrd",  mem_rd, 0);
    chk("s5_f3",     mem_funct3, 3'b010);
    chk("s5_wdata",  mem_wdata, 32'h0000FFFF);
    chk("s5_addr",   mem_addr, 9'h040);
    next_cycle();
    idle_inputs();
    #1;
    chk("s5_rvalid", dma_rvalid, 0);

    // Back-to-back DMA reads, one response per cycle
    next_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 9'h008; mem_rdata = 32'h0BAD0001;
    #1;
    chk("bb_gnt0",   dma_gnt, 1);
    next_cycle();
    dma_addr = 9'h00C; mem_rdata = 32'h0BAD0002;
    #1;
    chk("bb_gnt1",    dma_gnt, 1);
    chk("bb_rvalid1", dma_rvalid, 1);
    chk("bb_rdata1",  dma_rdata, 32'h0BAD0001);
    next_cycle();
    idle_inputs();
    #1;
    chk("bb_rvalid2", dma_rvalid, 1);
    chk("bb_rdata2",  dma_rdata, 32'h0BAD0002);
    chk("bb_gnt2",    dma_gnt, 0);

    // Reset asserted while in DMA_RSP
    next_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 9'h020; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("s6_gnt", dma_gnt, 1);
    next_cycle();
    cpu_rd = 1; cpu_addr = 9'h018; mem_rdata = 32'h00000000;
    #1;
    chk("s6_rvalid_pre", dma_rvalid, 1);
    chk("s6_rdata_pre",  dma_rdata, 32'hCAFEF00D);
    chk("s6_cpuwin",     dma_gnt, 0);
    reset = 1'b0;
    #1;
    chk("s6_rvalid_rst", dma_rvalid, 0);
    chk("s6_rdata_rst",  dma_rdata, 0);
    chk("s6_cnt_rst",    dut.u_starve.r_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("s6_cnt_rel",    dut.u_starve.r_cnt, 0);
    chk("s6_rvalid_rel", dma_rvalid, 0);
    chk("s6_gnt_rel",    dma_gnt, 0);
    next_cycle();
    #1;
    chk("s6_cnt_after",  dut.u_starve.r_cnt, 1);
    chk("s6_rvalid_aft", dma_rvalid, 0);
    chk("s6_memrd_aft",  mem_rd, 1);
    chk("s6_gnt_aft",    dma_gnt, 0);

    idle_inputs();
    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter
